i2c_eeprom_slave: RTL

Parametrised successor of the cartridge serial-EEPROM model: a two-wire (I2C-style) slave with configurable memory size, device address and page-write wrap.
- Sits between the PM I/O port pins (SCL/SDA, already open-drain combined upstream) and a dual-ported byte store.
- The store carries a host-side backdoor port so the MiSTer framework can load and save the backup file.
- Adds behaviour the first-generation model lacked: device-address match, per-page write wrap, current-address read, and a dirty flag.

---
 rtl/i2c_eeprom_slave.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: two-wire serial EEPROM slave with a host backdoor port.
// Matches DEV_ADDR, takes a two-byte word address, writes wrap inside a
// 2**PAGE_W-byte page, reads continue from the current pointer and wrap over
// the whole 2**ADDR_W store. dirty flags any two-wire write for save logic.
// Optional build macro I2C_EEPROM_WP_EN adds a wp input that blocks writes.
module i2c_eeprom_slave #(
    parameter int         ADDR_W   = 13,
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         PAGE_W   = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              data_in,
    output logic              data_out,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
`ifdef I2C_EEPROM_WP_EN
    input  logic              wp,
`endif
    output logic              dirty,
    input  logic              dirty_clr
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DEV     = 3'd1;
    localparam logic [2:0] ADDR_HI = 3'd2;
    localparam logic [2:0] ADDR_LO = 3'd3;
    localparam logic [2:0] WRITE   = 3'd4;
    localparam logic [2:0] READ    = 3'd5;

    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((1 << PAGE_W) - 1);

    logic [7:0]        mem [0:(2**ADDR_W)-1];

    logic              scl_q;
    logic              sda_q;
    logic [2:0]        state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;
    logic [7:0]        tx;
    logic [ADDR_W-1:0] ptr;
    logic              seen_rise;
    logic              rd_first;
    logic              mst_ack;

    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;
    logic              byte_done;
    logic              wr_block;
    logic              i2c_commit;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] ptr_page_inc;
    logic [ADDR_W-1:0] ptr_hi_next;
    logic [7:0]        rd_cur;
    logic [7:0]        rd_next;

`ifdef I2C_EEPROM_WP_EN
    assign wr_block = wp;
`else
    assign wr_block = 1'b0;
`endif

    assign scl_rise  = ce & ~scl_q;
    assign scl_fall  = ~ce & scl_q;
    assign start_det = ce & scl_q & sda_q & ~data_in;
    assign stop_det  = ce & scl_q & ~sda_q & data_in;

    // A byte ends on the falling edge that closes its eighth data bit.
    assign byte_done  = scl_fall & seen_rise & (bit_cnt == 4'd7) & (state != IDLE);
    assign i2c_commit = byte_done & (state == WRITE) & ~wr_block;

    assign ptr_inc      = ptr + ADDR_W'(1);
    assign ptr_page_inc = (ptr & ~PAGE_MASK) | (ptr_inc & PAGE_MASK);
    assign rd_cur       = mem[ptr];
    assign rd_next      = mem[ptr_inc];

    // Upper address byte lands in pointer bits above 7; excess bits are dropped.
    always_comb begin
        ptr_hi_next = ptr;
        for (int i = 8; i < ADDR_W; i++) begin
            ptr_hi_next[i] = shift[i-8];
        end
    end

    // Register the bus lines once so edges are seen as current vs. previous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= ce;
            sda_q <= data_in;
        end
    end

    // Protocol state machine: bit counting, shifting, ACK drive and pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            data_out  <= 1'b1;
            bit_cnt   <= 4'd0;
            shift     <= 8'd0;
            tx        <= 8'd0;
            ptr       <= '0;
            seen_rise <= 1'b0;
            rd_first  <= 1'b0;
            mst_ack   <= 1'b1;
        end else if (start_det) begin
            state     <= DEV;
            bit_cnt   <= 4'd0;
            shift     <= 8'd0;
            data_out  <= 1'b1;
            seen_rise <= 1'b0;
        end else if (stop_det) begin
            state    <= IDLE;
            data_out <= 1'b1;
        end else if (state != IDLE) begin
            if (scl_rise) begin
                seen_rise <= 1'b1;
                if (bit_cnt < 4'd8) shift   <= {shift[6:0], data_in};
                else                mst_ack <= data_in;
            end
            // The first fall after START has no preceding rise and is not a bit.
            if (scl_fall && seen_rise) begin
                seen_rise <= 1'b0;
                if (bit_cnt == 4'd8) begin
                    bit_cnt <= 4'd0;
                    if (state == READ) begin
                        if (rd_first) begin
                            rd_first <= 1'b0;
                            data_out <= rd_cur[7];
                            tx       <= {rd_cur[6:0], 1'b0};
                        end else if (!mst_ack) begin
                            ptr      <= ptr_inc;
                            data_out <= rd_next[7];
                            tx       <= {rd_next[6:0], 1'b0};
                        end else begin
                            ptr      <= ptr_inc;
                            state    <= IDLE;
                            data_out <= 1'b1;
                        end
                    end else begin
                        data_out <= 1'b1;
                    end
                end else if (bit_cnt == 4'd7) begin
                    bit_cnt <= 4'd8;
                    case (state)
                        DEV: begin
                            if (shift[7:1] == DEV_ADDR) begin
                                data_out <= 1'b0;
                                state    <= shift[0] ? READ : ADDR_HI;
                                rd_first <= shift[0];
                            end else begin
                                state <= IDLE;
                            end
                        end
                        ADDR_HI: begin
                            data_out <= 1'b0;
                            ptr      <= ptr_hi_next;
                            state    <= ADDR_LO;
                        end
                        ADDR_LO: begin
                            data_out <= 1'b0;
                            ptr[7:0] <= shift;
                            state    <= WRITE;
                        end
                        WRITE: begin
                            data_out <= 1'b0;
                            ptr      <= ptr_page_inc;
                        end
                        default: data_out <= 1'b1;
                    endcase
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (state == READ) begin
                        data_out <= tx[7];
                        tx       <= {tx[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Byte store write port: host backdoor has priority over the bus.
    always_ff @(posedge clk) begin
        if (host_we)         mem[host_addr] <= host_wdata;
        else if (i2c_commit) mem[ptr]       <= shift;
    end

    // Host backdoor read, one cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) host_rdata <= 8'd0;
        else          host_rdata <= mem[host_addr];
    end

    // Dirty flag: a bus write beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        dirty <= 1'b0;
        else if (i2c_commit) dirty <= 1'b1;
        else if (dirty_clr)  dirty <= 1'b0;
    end

endmodule
